data_memory: RTL and testbench

//   Single-port synchronous data memory (default 256 x 8) for the datapath load/store stage.

---
 rtl/data_memory_if.sv | 39 +++
 rtl/data_memory.sv | 84 ++++++++
 tb/tb_data_memory.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/data_memory_if.sv
// Bus interface for data_memory: address, write data, write/read enables,
// registered read data and (when DATAMEM_PARITY_EN is defined) the parity flag.
interface data_memory_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic [ADDR_W-1:0] adr;
  logic [DATA_W-1:0] datain;
  logic              w;
  logic              r;
  logic [DATA_W-1:0] dataout;
`ifdef DATAMEM_PARITY_EN
  logic              par_err;
`endif

  // Requester side: drives the request, observes read data.
  modport master (
    output adr,
    output datain,
    output w,
    output r,
`ifdef DATAMEM_PARITY_EN
    input  par_err,
`endif
    input  dataout
  );

  // Memory side.
  modport slave (
    input  adr,
    input  datain,
    input  w,
    input  r,
`ifdef DATAMEM_PARITY_EN
    output par_err,
`endif
    output dataout
  );
endinterface

// File: rtl/data_memory.sv
// Single-port synchronous data memory with registered, held read data.
// Write-first when w and r coincide. Asynchronous active-low reset clears
// the whole array and the read register.
// Optional feature: define DATAMEM_PARITY_EN to store an even-parity bit per
// word and flag corrupted reads on par_err.
module data_memory #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 1 << ADDR_W
) (
  input  logic          clk,
  input  logic          rst_n,
  data_memory_if.slave  bus
);

`ifdef DATAMEM_PARITY_EN
  localparam int unsigned WordW = DATA_W + 1;
`else
  localparam int unsigned WordW = DATA_W;
`endif

  logic [WordW-1:0]  r_mem [DEPTH];
  logic [DATA_W-1:0] r_dataout;
  logic [WordW-1:0]  w_wr_word;
  logic [WordW-1:0]  w_rd_word;
`ifdef DATAMEM_PARITY_EN
  logic              r_par_err;
  logic              w_rd_bad;
`endif

  // Stored word image for a write, and the raw word at the current address.
  always_comb begin
`ifdef DATAMEM_PARITY_EN
    w_wr_word = {^bus.datain, bus.datain};
`else
    w_wr_word = bus.datain;
`endif
    w_rd_word = r_mem[bus.adr];
  end

`ifdef DATAMEM_PARITY_EN
  // Recomputed parity of the stored data disagreeing with the stored parity bit.
  always_comb begin
    w_rd_bad = (^w_rd_word[DATA_W-1:0]) != w_rd_word[DATA_W];
  end
`endif

  // Memory array: cleared on reset, written on w.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem <= '{default: '0};
    end else if (bus.w) begin
      r_mem[bus.adr] <= w_wr_word;
    end
  end

  // Read register: loads on r, bypasses write data when w is also set, holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dataout <= '0;
`ifdef DATAMEM_PARITY_EN
      r_par_err <= 1'b0;
`endif
    end else if (bus.r) begin
      if (bus.w) begin
        r_dataout <= bus.datain;
`ifdef DATAMEM_PARITY_EN
        r_par_err <= 1'b0;
`endif
      end else begin
        r_dataout <= w_rd_word[DATA_W-1:0];
`ifdef DATAMEM_PARITY_EN
        r_par_err <= w_rd_bad;
`endif
      end
    end
  end

  assign bus.dataout = r_dataout;
`ifdef DATAMEM_PARITY_EN
  assign bus.par_err = r_par_err;
`endif

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed scenarios followed by random
// traffic, compared against an array-based reference model.
module tb_data_memory;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic clk;
  logic rst_n;

  data_memory_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  data_memory #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [DATA_W-1:0] ref_out;
  logic              ref_par;
  bit                ref_bad [DEPTH];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i] = '0;
      ref_bad[i] = 1'b0;
    end
    ref_out = '0;
    ref_par = 1'b0;
  endtask

  // One request cycle; called at a negedge, returns at the next negedge.
  task automatic step(input logic wr, input logic rd, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d);
    bus.w = wr; bus.r = rd; bus.adr = a; bus.datain = d;
    @(posedge clk);
    if (rd) begin
      ref_out = wr ? d : ref_mem[a];
      ref_par = wr ? 1'b0 : ref_bad[a];
    end
    if (wr) begin
      ref_mem[a] = d;
      ref_bad[a] = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic check_out(input string tag);
    check(tag, 32'(bus.dataout), 32'(ref_out));
`ifdef DATAMEM_PARITY_EN
    check({tag, "_par"}, 32'(bus.par_err), 32'(ref_par));
`endif
  endtask

  // Pulse reset between edges; holds it across one posedge with live requests.
  task automatic pulse_reset(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check({tag, "_async"}, 32'(bus.dataout), 32'h0);
    bus.w = 1'b1; bus.r = 1'b1; bus.adr = 8'h10; bus.datain = 8'h99;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_held"}, 32'(bus.dataout), 32'h0);
    #1 rst_n = 1'b1;
    bus.w = 1'b0; bus.r = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [DATA_W-1:0] v;
    rst_n = 1'b1;
    bus.w = 1'b0; bus.r = 1'b0; bus.adr = '0; bus.datain = '0;
    model_reset();

    // 1: reset, then reads of cleared words
    pulse_reset("rst1");
    step(1'b0, 1'b1, 8'h00, 8'h00); check_out("rd00_rst");
    step(1'b0, 1'b1, 8'h0A, 8'h00); check_out("rd0A_rst");
    step(1'b0, 1'b1, 8'hFF, 8'h00); check_out("rdFF_rst");
    // Write under reset must have been discarded
    step(1'b0, 1'b1, 8'h10, 8'h00); check_out("rd10_rst_wr");

    // 2: write then read
    step(1'b1, 1'b0, 8'h00, 8'hFF); check_out("wr00_hold");
    step(1'b0, 1'b1, 8'h00, 8'h00); check_out("rd00_FF");

    // 3: write-first bypass
    step(1'b1, 1'b1, 8'h0A, 8'h55); check_out("bypass55");
    step(1'b0, 1'b1, 8'hFF, 8'h00); check_out("rdFF_again");
    step(1'b0, 1'b1, 8'h0A, 8'h00); check_out("rd0A_55");

    // 4: hold with r=0 while adr/datain change
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 8'($urandom), 8'($urandom));
      check_out("hold55");
    end

    // 5: write, reset mid-cycle, read back cleared
    step(1'b1, 1'b1, 8'h10, 8'hA5); check_out("bypassA5");
    pulse_reset("rst5");
    step(1'b0, 1'b1, 8'h10, 8'h00); check_out("rd10_cleared");
    step(1'b0, 1'b1, 8'h00, 8'h00); check_out("rd00_cleared");

`ifdef DATAMEM_PARITY_EN
    // 6: parity
    step(1'b1, 1'b0, 8'h30, 8'h3C);
    step(1'b0, 1'b1, 8'h30, 8'h00); check_out("par_clean");
    v = dut.r_mem[8'h30][DATA_W-1:0] ^ 8'h01;
    dut.r_mem[8'h30][DATA_W-1:0] = v;
    ref_mem[8'h30] = ref_mem[8'h30] ^ 8'h01;
    ref_bad[8'h30] = 1'b1;
    step(1'b0, 1'b1, 8'h30, 8'h00); check_out("par_corrupt");
    step(1'b0, 1'b0, 8'h31, 8'h00); check_out("par_hold");
    step(1'b0, 1'b1, 8'h31, 8'h00); check_out("par_unwritten");
    step(1'b1, 1'b1, 8'h30, 8'h0F); check_out("par_bypass");
    step(1'b0, 1'b1, 8'h30, 8'h00); check_out("par_rewritten");
`else
    v = '0;
`endif

    // Random traffic, addresses biased to a small window so reads hit writes
    for (int i = 0; i < 400; i++) begin
      logic [ADDR_W-1:0] a;
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      step(1'($urandom), 1'($urandom), a, 8'($urandom) ^ v);
      check_out("rand");
    end

    // Readback sweep of the window
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'(i), 8'h00);
      check_out("sweep");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
